// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter
//   Shares one single-port, variable-latency unified memory between the
//   instruction-fetch port and the MEM-stage data port. Data wins by default.
//   A starvation counter forces a fetch grant after STARVE_LIM consecutive
//   data grants made while fetch was waiting. A wait counter aborts a
//   transaction that sees no mem_ready for TIMEOUT busy cycles and sets a
//   sticky error flag.
//
// Ports
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_if_req, i_if_addr            fetch request (held until o_if_ack) / address
//   o_if_rdata, o_if_ack           fetched word (held) / one-cycle completion
//   i_dm_req, i_dm_we              data request (held until o_dm_ack) / 1=store
//   i_dm_addr, i_dm_wdata          data address / store data
//   o_dm_rdata, o_dm_ack           load data (held) / one-cycle completion
//   o_mem_req, o_mem_we            registered memory request / write enable
//   o_mem_addr, o_mem_wdata        registered address / write data
//   i_mem_rdata, i_mem_ready       memory read data / one-cycle completion
//   o_stall_if, o_stall_mem        request pending and not yet acknowledged
//   o_err                          sticky timeout flag
module pipe_mem_arbiter #(
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_ack,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_stall_if,
  output logic        o_stall_mem,
  output logic        o_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_BUSY = 2'd1;
  localparam logic [1:0] S_DM_BUSY = 2'd2;

  localparam logic [2:0] C_STARVE_LIM = 3'(STARVE_LIM);
  localparam logic [3:0] C_TIMEOUT    = 4'(TIMEOUT);

  logic [1:0]  r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_if_ack;
  logic        r_dm_ack;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_err;
  logic [2:0]  r_starve_cnt;
  logic [3:0]  r_wait_cnt;

  logic        w_grant_dm;
  logic        w_grant_if;
  logic        w_done;
  logic        w_abort;
  logic [31:0] w_rdata;

  always_comb begin
    w_grant_dm = i_dm_req & ((r_starve_cnt < C_STARVE_LIM) | ~i_if_req);
    w_grant_if = ~w_grant_dm & i_if_req;
    // mem_ready wins over an abort landing in the same cycle.
    w_abort    = ~i_mem_ready & (r_wait_cnt == C_TIMEOUT);
    w_done     = i_mem_ready | w_abort;
    w_rdata    = i_mem_ready ? i_mem_rdata : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_err        <= 1'b0;
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_state     <= S_DM_BUSY;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_dm_we;
            r_mem_addr  <= i_dm_addr;
            r_mem_wdata <= i_dm_wdata;
            r_wait_cnt  <= '0;
            if (i_if_req && (r_starve_cnt != '1)) begin
              r_starve_cnt <= r_starve_cnt + 3'd1;
            end
          end else if (w_grant_if) begin
            r_state      <= S_IF_BUSY;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= i_if_addr;
            r_mem_wdata  <= '0;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
          end
        end
        S_IF_BUSY, S_DM_BUSY: begin
          if (w_done) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            if (w_abort) begin
              r_err <= 1'b1;
            end
            if (r_state == S_IF_BUSY) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_rdata;
            end else begin
              r_dm_ack <= 1'b1;
              // Stores never touch the load-data register.
              if (!r_mem_we) begin
                r_dm_rdata <= w_rdata;
              end
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_ack    = r_if_ack;
  assign o_dm_ack    = r_dm_ack;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_err       = r_err;
  assign o_stall_if  = i_if_req & ~r_if_ack;
  assign o_stall_mem = i_dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Testbench for pipe_mem_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level reference model.
module tb_pipe_mem_arbiter;

  localparam int STARVE_LIM = 4;
  localparam int TIMEOUT    = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_req, mem_we, stall_if, stall_mem, err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_starve;
  bit          m_err;
  logic [31:0] m_if_rdata, m_dm_rdata;

  always #5 clk = ~clk;

  pipe_mem_arbiter #(.STARVE_LIM(STARVE_LIM), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ack(if_ack),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_rdata(dm_rdata), .o_dm_ack(dm_ack),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
    .o_stall_if(stall_if), .o_stall_mem(stall_mem), .o_err(err)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: observed=no-finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_dm();
    dm_req   = 1'b1;
    dm_we    = 1'($urandom % 2);
    dm_addr  = $urandom & 32'hFFFF_FFFC;
    dm_wdata = $urandom;
  endtask

  // One complete transaction. Called while the DUT is idle with at least one
  // request driven; the grant happens at the next edge. lat = busy cycles up
  // to and including the mem_ready cycle (0 = memory never answers).
  task automatic txn(input int lat, input logic [31:0] data, input bit raise_other,
                     input bit drop_early, output logic [31:0] gaddr);
    bit          exp_dm, tmo;
    logic        e_we;
    logic [31:0] e_addr, e_wdata, e_rd;
    int          ack_t;
    exp_dm  = dm_req && (m_starve < STARVE_LIM || !if_req);
    e_addr  = exp_dm ? dm_addr : if_addr;
    e_we    = exp_dm ? dm_we : 1'b0;
    e_wdata = exp_dm ? dm_wdata : 32'h0;
    if (exp_dm) begin
      if (if_req) m_starve = (m_starve < 7) ? m_starve + 1 : 7;
    end else begin
      m_starve = 0;
    end
    tmo   = (lat == 0) || (lat > TIMEOUT + 1);
    ack_t = tmo ? TIMEOUT + 1 : lat;
    e_rd  = tmo ? 32'h0 : data;

    step();
    gaddr = mem_addr;
    chk("grant_addr", mem_addr, e_addr);
    chk("grant_we", {31'b0, mem_we}, {31'b0, e_we});
    chk("grant_wdata", mem_wdata, e_wdata);
    chk("busy_stall_if", {31'b0, stall_if}, {31'b0, if_req});
    chk("busy_stall_mem", {31'b0, stall_mem}, {31'b0, dm_req});
    if (drop_early) begin
      if (exp_dm) dm_req = 1'b0; else if_req = 1'b0;
    end
    for (int t = 0; t < ack_t; t++) begin
      chk("busy_mem_req", {31'b0, mem_req}, 32'd1);
      chk("busy_acks", {30'b0, if_ack, dm_ack}, 32'd0);
      if (t == 1 && raise_other) begin
        if (exp_dm && !if_req) new_if();
        if (!exp_dm && !dm_req) new_dm();
      end
      mem_ready = (t == lat - 1);
      mem_rdata = (t == lat - 1) ? data : $urandom;
      step();
    end

    if (exp_dm) begin
      if (!e_we) m_dm_rdata = e_rd;
    end else begin
      m_if_rdata = e_rd;
    end
    if (tmo) m_err = 1'b1;

    chk("ack_if", {31'b0, if_ack}, {31'b0, !exp_dm});
    chk("ack_dm", {31'b0, dm_ack}, {31'b0, exp_dm});
    chk("ack_if_rdata", if_rdata, m_if_rdata);
    chk("ack_dm_rdata", dm_rdata, m_dm_rdata);
    chk("ack_mem_req", {31'b0, mem_req}, 32'd0);
    chk("ack_err", {31'b0, err}, {31'b0, m_err});
    if (exp_dm) chk("ack_stall_mem", {31'b0, stall_mem}, 32'd0);
    else        chk("ack_stall_if", {31'b0, stall_if}, 32'd0);
    if (exp_dm) dm_req = 1'b0; else if_req = 1'b0;
    // A stray mem_ready seen by the idle arbiter must be ignored.
    mem_ready = 1'($urandom % 2);
    mem_rdata = $urandom;
  endtask

  initial begin
    logic [31:0] ga;
    logic [31:0] exp_seq [6];
    int r, lat;

    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    m_starve = 0; m_err = 1'b0; m_if_rdata = '0; m_dm_rdata = '0;
    step(); step();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", {30'b0, if_ack, dm_ack}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single fetch, memory answers in the first busy cycle.
    if_req = 1'b1; if_addr = 32'h40;
    txn(1, 32'h8C22_0004, 1'b0, 1'b0, ga);
    chk("fetch_addr", ga, 32'h40);
    chk("fetch_rdata", if_rdata, 32'h8C22_0004);

    // Load to give dm_rdata a known value, then simultaneous store + fetch.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_wdata = 32'h0;
    txn(2, 32'h1234_5678, 1'b0, 1'b0, ga);
    chk("load_rdata", dm_rdata, 32'h1234_5678);
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    txn(1, 32'h5555_AAAA, 1'b0, 1'b0, ga);
    chk("simul_first_dm", ga, 32'h10);
    txn(1, 32'h0000_0013, 1'b0, 1'b0, ga);
    chk("simul_then_if", ga, 32'h80);
    chk("store_keeps_dm_rdata", dm_rdata, 32'h1234_5678);

    // Starvation: fetch held, data re-requested every idle cycle.
    exp_seq = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100, 32'h200};
    for (int i = 0; i < 6; i++) begin
      if_req = 1'b1; if_addr = 32'h100;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
      txn(1 + (i % 3), $urandom, 1'b0, 1'b0, ga);
      chk($sformatf("starve_grant%0d", i), ga, exp_seq[i]);
    end
    dm_req = 1'b0;

    // Non-preemption: fetch in progress, data arrives next cycle and waits.
    if_req = 1'b1; if_addr = 32'h300;
    txn(3, 32'hCAFE_0001, 1'b1, 1'b0, ga);
    chk("nopreempt_if", ga, 32'h300);
    chk("nopreempt_dm_pending", {31'b0, dm_req}, 32'd1);
    txn(2, 32'hCAFE_0002, 1'b0, 1'b0, ga);
    chk("nopreempt_dm_next", ga, dm_addr);

    // Timeout on a load, then err stays set through a normal transaction.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
    txn(0, 32'hFFFF_FFFF, 1'b0, 1'b0, ga);
    chk("tmo_dm_rdata", dm_rdata, 32'h0);
    chk("tmo_err", {31'b0, err}, 32'd1);
    if_req = 1'b1; if_addr = 32'h44;
    txn(16, 32'h0BAD_F00D, 1'b0, 1'b0, ga);
    chk("ready_at_limit_completes", if_rdata, 32'h0BAD_F00D);
    chk("err_sticky", {31'b0, err}, 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if (!if_req && ($urandom % 2 == 1)) new_if();
      if (!dm_req && ($urandom % 2 == 1)) new_dm();
      if (!if_req && !dm_req) new_if();
      r   = int'($urandom % 20);
      lat = (r == 0) ? 0 : (r == 1) ? 16 : (r == 2) ? 17 : 1 + int'($urandom % 5);
      txn(lat, $urandom, ($urandom % 4 == 0), ($urandom % 8 == 0), ga);
    end

    // Reset in the middle of a data transaction.
    mem_ready = 1'b0; if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
    step();
    chk("prerst_mem_req", {31'b0, mem_req}, 32'd1);
    chk("prerst_addr", mem_addr, 32'h600);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_err", {31'b0, err}, 32'd0);
    chk("midrst_rdata", if_rdata | dm_rdata, 32'd0);
    step();
    chk("inrst_acks", {30'b0, if_ack, dm_ack}, 32'd0);
    rst_n = 1'b1; dm_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h500;
    m_starve = 0; m_err = 1'b0; m_if_rdata = '0; m_dm_rdata = '0;
    txn(2, 32'h7777_0000, 1'b0, 1'b0, ga);
    chk("postrst_if_grant", ga, 32'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arbiter.md
# pipe_mem_arbiter

Arbiter and sequencer that shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch stage and its MEM-stage data access. It owns a 3-state grant FSM and drives the memory request/ready handshake. It returns per-port acknowledges and produces the stall signals that freeze the PC/IF_ID registers or the whole pipeline. Data accesses win by default, and a starvation counter guarantees fetch progress.

## Interface
- STARVE_LIM, 4: consecutive data grants tolerated while fetch waits before fetch is forced to win.
- TIMEOUT, 15: busy cycles without mem_ready before a transaction is aborted (4-bit counter, 1..15).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction; valid with if_ack, held until next if_ack.
- if_ack  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; valid with dm_ack on loads, held otherwise.
- dm_ack  out  1  one-cycle completion pulse for data.
- mem_req  out  1  registered memory request.
- mem_we  out  1  registered write enable.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered write data.
- mem_rdata  in  32  memory read data; valid when mem_ready = 1.
- mem_ready  in  1  memory completion, one cycle.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_mem  out  1  dm_req & ~dm_ack (combinational).
- err  out  1  sticky timeout flag.

## Operation
- FSM states:
  - IDLE: no transaction.
  - IF_BUSY: fetch owns the memory.
  - DM_BUSY: data owns the memory.
- IDLE arbitration uses the requests present this cycle:
  - if dm_req and (starve_cnt < STARVE_LIM or !if_req): go to DM_BUSY.
  - else if if_req: go to IF_BUSY.
  - else stay in IDLE.
- On entering a busy state, register mem_req=1, mem_addr, mem_we (0 for fetch, dm_we for data) and mem_wdata (0 for fetch).
- Grants are non-preemptive. A dm_req arriving during IF_BUSY waits for the fetch to finish.
- Busy state sees mem_ready=1:
  - Latch mem_rdata into the owner's rdata register. A data store leaves dm_rdata unchanged.
  - Pulse the owner's ack.
  - Drop mem_req.
  - Return to IDLE.
- Starvation counter (3 bits, saturating):
  - Increments on each DM grant made while if_req=1.
  - Clears on any IF grant.
- Timeout: wait_cnt clears on entering a busy state and increments each busy cycle without mem_ready. When it reaches TIMEOUT:
  - abort the transaction: mem_req drops, owner ack pulses with rdata = 0 (stores: dm_rdata unchanged);
  - set err (cleared only by reset);
  - return to IDLE.
- mem_ready while in IDLE is ignored.
- A requester dropping req mid-transaction does not cancel it. The transaction completes and the ack still pulses.
- Reset values:
  - FSM = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - if_ack, dm_ack, if_rdata, dm_rdata, err = 0.
  - starve_cnt, wait_cnt = 0.

## Timing
- Cycle N: FSM in IDLE with a request pending → busy state and mem_req=1 from N+1.
- mem_ready sampled high at cycle M → ack=1, rdata valid, mem_req=0, IDLE at M+1.
- Minimum request-to-ack latency: 2 cycles (mem_ready at N+1, ack at N+2).
- Back-to-back transactions: the next grant is decided in the IDLE cycle M+1, so mem_req is high again at M+2. There is a 1-cycle bubble between transactions.
- Timeout abort: ack is high at the cycle after wait_cnt reaches TIMEOUT, i.e. N+1+TIMEOUT+1 when mem_ready never comes.
- mem_ready arriving in the same cycle the counter hits TIMEOUT wins: normal completion, err is not set.
- stall_if and stall_mem are combinational and fall in the ack cycle.
- Reset assertion mid-transaction clears all state asynchronously. mem_req falls immediately without waiting for a clock edge, and no ack is issued.

## Test plan
- Single fetch: if_req=1, if_addr=0x40, mem_ready one cycle after mem_req with mem_rdata=0x8C220004 → if_ack pulse 2 cycles after req, if_rdata=0x8C220004, stall_if low in the ack cycle.
- Simultaneous requests: if_req=dm_req=1 at same cycle, store dm_addr=0x10 dm_wdata=0xDEADBEEF → data granted first (mem_we=1, mem_addr=0x10), then fetch granted at the next IDLE. dm_rdata stays unchanged.
- Starvation: if_req held high, dm_req re-asserted every IDLE → exactly 4 consecutive data grants, then a fetch grant, then data resumes.
- Timeout: dm_req load, mem_ready never asserted → dm_ack with dm_rdata=0 and err=1 on cycle N+17. err stays 1 through subsequent normal transactions until reset.
- Non-preemption and bubble: fetch granted, dm_req raised next cycle, mem_ready after 3 cycles → if_ack first. IDLE cycle follows, then mem_req for data.
- Reset mid-transaction: pull reset low while in DM_BUSY → mem_req, acks and counters go to 0 immediately. After release, a pending if_req is granted normally.
